// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
//   SEG_BLANK / SEG_0..SEG_F : active-low glyphs, bit order {a,b,c,d,e,f,g}
//   scan_state_t             : scan FSM states
//   seg_encode()             : nibble -> glyph; in decimal mode 10..15 decode to blank
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble, input logic hex_mode);
    logic [6:0] glyph;
    case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      default: glyph = SEG_F;
    endcase
    // Decimal mode shows nothing for 10..15 rather than a misleading letter.
    if (!hex_mode && nibble > 4'h9) glyph = SEG_BLANK;
    return glyph;
  endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational glyph decoder for one digit.
//   nibble   in  4  value to show
//   hex_mode in  1  1 = 0-F, 0 = 0-9 (10-15 blank)
//   blank    in  1  force all segments off (leading-zero suppression)
//   seg      out 7  active-low {a,b,c,d,e,f,g}
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg_encode(nibble, hex_mode);
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// N-digit multiplexed 7-segment scan controller.
// Each digit gets a slot of CLK_HZ/SCAN_HZ cycles: BLANK_CYCLES all-off (anti-ghost)
// followed by DWELL cycles where the digit is driven, PWM-gated by brightness.
// Digit data, hex_mode and lz_blank are snapshotted once per frame so a frame never tears.
// Optional feature macro: SEVENSEG_DP_EN adds dp_mask input and dp output.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   en             1 = scan, 0 = dark (restarts at digit 0 when raised)
//   digits         nibble i = digits[4i+3:4i], digit 0 least significant
//   hex_mode       1 = 0-F, 0 = 0-9 with 10-15 blank
//   lz_blank       suppress leading zeros (digit 0 always shown)
//   brightness     PWM duty, 15 = full on, 0 = off (sampled live)
//   dp_mask / dp   (SEVENSEG_DP_EN only) per-digit decimal point, dp active-low
//   an             active-low digit enables
//   seg            active-low {a,b,c,d,e,f,g}
//   frame_done     1-cycle pulse with the last ON cycle of the last digit
// All outputs are registered and lag the FSM state by one cycle.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 4_000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
`ifdef SEVENSEG_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    dp,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_done
);

  localparam int SLOT  = CLK_HZ / SCAN_HZ;
  localparam int DWELL = SLOT - BLANK_CYCLES;
  localparam int CW    = $clog2(SLOT);
  localparam int IW    = $clog2(NUM_DIGITS);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("sevenseg_scan_ctrl: NUM_DIGITS must be 2..8");
  end
  // The BLANK state lasts at least one cycle, so a zero-length gap is not representable.
  if (BLANK_CYCLES < 1 || SLOT < BLANK_CYCLES + 16) begin : g_bad_slot
    $error("sevenseg_scan_ctrl: need BLANK_CYCLES >= 1 and SLOT >= BLANK_CYCLES+16");
  end

  scan_state_t             state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [3:0]              pwm_cnt;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic                    snap_hex;
  logic                    snap_lz;
`ifdef SEVENSEG_DP_EN
  logic [NUM_DIGITS-1:0]   snap_dp;
`endif

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_above;
  logic [3:0]              cur_nibble;
  logic [6:0]              dec_seg;
  logic                    lit;
  logic                    last_idx;

  // Walk from the most significant digit down: a digit is a leading zero while
  // every digit from it upward is zero. Digit 0 is never suppressed.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (snap_digits[4*i +: 4] == 4'h0);
      lz_mask[i] = snap_lz & zero_above & (i != 0);
    end
  end

  always_comb begin
    cur_nibble = snap_digits[4*idx +: 4];
    lit        = (brightness == 4'hF) | (pwm_cnt < brightness);
    last_idx   = (idx == IW'(NUM_DIGITS - 1));
  end

  sevenseg_decoder u_decoder (
    .nibble   (cur_nibble),
    .hex_mode (snap_hex),
    .blank    (lz_mask[idx]),
    .seg      (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      pwm_cnt     <= '0;
      snap_digits <= '0;
      snap_hex    <= 1'b0;
      snap_lz     <= 1'b0;
      an          <= '1;
      seg         <= SEG_BLANK;
      frame_done  <= 1'b0;
`ifdef SEVENSEG_DP_EN
      snap_dp     <= '0;
      dp          <= 1'b1;
`endif
    end else begin
      // Outputs: decoded from the current state; en is used live so dropping
      // it darkens the display on the very next cycle.
      an         <= '1;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
`ifdef SEVENSEG_DP_EN
      dp         <= 1'b1;
`endif
      if (en && state == ON) begin
        seg <= dec_seg;
        if (lit) begin
          an <= ~(NUM_DIGITS'(1) << idx);
`ifdef SEVENSEG_DP_EN
          dp <= ~snap_dp[idx];
`endif
        end
      end

      // Next state.
      if (!en) begin
        state   <= IDLE;
        idx     <= '0;
        cnt     <= '0;
        pwm_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state       <= BLANK;
            idx         <= '0;
            cnt         <= '0;
            snap_digits <= digits;
            snap_hex    <= hex_mode;
            snap_lz     <= lz_blank;
`ifdef SEVENSEG_DP_EN
            snap_dp     <= dp_mask;
`endif
          end
          BLANK: begin
            if (cnt == CW'(BLANK_CYCLES - 1)) begin
              state   <= ON;
              cnt     <= '0;
              pwm_cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ON: begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (cnt == CW'(DWELL - 1)) begin
              state <= BLANK;
              cnt   <= '0;
              if (last_idx) begin
                idx         <= '0;
                frame_done  <= 1'b1;
                snap_digits <= digits;
                snap_hex    <= hex_mode;
                snap_lz     <= lz_blank;
`ifdef SEVENSEG_DP_EN
                snap_dp     <= dp_mask;
`endif
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl (NUM_DIGITS=4, SLOT=20, BLANK_CYCLES=2, DWELL=18).
// Build with SEVENSEG_DP_EN defined to exercise the decimal-point option.
module tb_sevenseg_scan_ctrl;

  localparam int DWELL = 18;
  localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b0, 1'b1};

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic        hex_mode;
  logic        lz_blank;
  logic [3:0]  brightness;
  logic [3:0]  dp_mask_v;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
  logic        dp_obs;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .CLK_HZ       (1000),
    .SCAN_HZ      (50),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits     (digits),
    .hex_mode   (hex_mode),
    .lz_blank   (lz_blank),
    .brightness (brightness),
`ifdef SEVENSEG_DP_EN
    .dp_mask    (dp_mask_v),
    .dp         (dp_obs),
`endif
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

`ifndef SEVENSEG_DP_EN
  assign dp_obs = 1'b1;
`endif

  // ---------------- scoreboard ----------------
  // Entry = {an[3:0], seg[6:0], frame_done, dp}, one per clock.
  logic [12:0] exp_q[$];
  logic [12:0] exp_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          push_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      check("scan", {19'd0, an, seg, frame_done, dp_obs}, {19'd0, exp_e});
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input int s,
                                         input logic hx, input logic lz);
    logic [3:0] nib;
    bit lead;
    nib  = d[4*s +: 4];
    lead = lz && (s != 0);
    for (int j = s; j < 4; j++) if (d[4*j +: 4] != 4'h0) lead = 1'b0;
    if (lead) return 7'h7F;
    if (!hx && nib > 4'h9) return 7'h7F;
    return glyph(nib);
  endfunction

  task automatic push_one(input logic [12:0] v);
    if (push_left > 0) begin
      exp_q.push_back(v);
      push_left--;
    end
  endtask

  // Expected output stream after en (or reset release) is driven just past a clock
  // edge: one sample before the enabling edge, one idle cycle of latency, then
  // per digit 2 dark cycles and 18 ON cycles. Frame 0 shows d0, later frames d1.
  task automatic push_stream(input int ncyc, input logic [15:0] d0, input logic [15:0] d1,
                             input logic hx, input logic lz, input logic [3:0] br);
    logic [15:0] d;
    logic [3:0]  mask;
    logic [3:0]  an_e;
    logic        lit;
`ifdef SEVENSEG_DP_EN
    mask = dp_mask_v;
`else
    mask = 4'h0;
`endif
    push_left = ncyc;
    push_one(DARK);
    push_one(DARK);
    for (int f = 0; push_left > 0; f++) begin
      d = (f == 0) ? d0 : d1;
      for (int s = 0; s < 4; s++) begin
        push_one(DARK);
        push_one(DARK);
        for (int k = 0; k < DWELL; k++) begin
          lit  = (br == 4'hF) || ((k % 16) < int'(br));
          an_e = lit ? ~(4'b0001 << s) : 4'hF;
          push_one({an_e, exp_seg(d, s, hx, lz), (s == 3 && k == DWELL - 1),
                    lit ? ~mask[s] : 1'b1});
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_scan(input int ncyc, input logic [15:0] d0, input logic [15:0] d1,
                            input logic hx, input logic lz, input logic [3:0] br);
    @(posedge clk);
    #1;
    digits     = d0;
    hex_mode   = hx;
    lz_blank   = lz;
    brightness = br;
    en         = 1'b1;
    push_stream(ncyc, d0, d1, hx, lz, br);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic go_dark();
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_frames(input int nframes, input logic [15:0] d, input logic hx,
                            input logic lz, input logic [3:0] br);
    start_scan(2 + 80 * nframes, d, d, hx, lz, br);
    drain();
    go_dark();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    digits     = 16'h0000;
    hex_mode   = 1'b0;
    lz_blank   = 1'b0;
    brightness = 4'hF;
    dp_mask_v  = 4'b0010;

    // Reset held for two edges with en high: display stays dark.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_fd", frame_done, 1'b0);
      check("rst_dp", dp_obs, 1'b1);
    end
    @(posedge clk);
    #1;
    en    = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Scan order and frame_done period.
    run_frames(2, 16'h4321, 1'b0, 1'b0, 4'hF);

    // Leading-zero suppression.
    run_frames(1, 16'h0070, 1'b0, 1'b1, 4'hF);
    run_frames(1, 16'h0000, 1'b0, 1'b1, 4'hF);

    // Hex vs decimal decode of 0xA in digit 0.
    run_frames(1, 16'h000A, 1'b1, 1'b0, 4'hF);
    run_frames(1, 16'h000A, 1'b0, 1'b0, 4'hF);

    // Snapshot: digits change while digit 1 is on; takes effect next frame.
    start_scan(2 + 160, 16'h4321, 16'h8765, 1'b0, 1'b0, 4'hF);
    repeat (30) @(posedge clk);
    #1;
    digits = 16'h8765;
    drain();
    go_dark();

    // PWM duty.
    run_frames(1, 16'h1234, 1'b0, 1'b0, 4'd4);
    run_frames(1, 16'h1234, 1'b0, 1'b0, 4'd0);

    // en dropped mid-slot (digit 1 lit), then re-enabled from digit 0.
    start_scan(32, 16'h5678, 16'h5678, 1'b1, 1'b0, 4'hF);
    repeat (31) @(posedge clk);
    #1;
    en = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(DARK);
    drain();
    run_frames(1, 16'h9ABC, 1'b1, 1'b0, 4'hF);

    // Reset in the middle of a scan behaves like power-on reset.
    start_scan(50, 16'h2468, 16'h2468, 1'b0, 1'b0, 4'hF);
    repeat (49) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(DARK);
    drain();
    #1;
    rst_n = 1'b1;
    push_stream(82, 16'h2468, 16'h2468, 1'b0, 1'b0, 4'hF);
    drain();
    go_dark();

    // Randomised settings.
    for (int r = 0; r < 6; r++) begin
      logic [15:0] rd;
      logic [15:0] zmask;
      case ($urandom_range(0, 3))
        0: zmask = 16'hFFFF;
        1: zmask = 16'h0FFF;
        2: zmask = 16'h00FF;
        default: zmask = 16'h000F;
      endcase
      rd        = 16'($urandom) & zmask;
      dp_mask_v = 4'($urandom_range(0, 15));
      run_frames(1, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
